// File: rtl/uart_pkg.sv
// Shared constants and types for the UART RX line buffer.
package uart_pkg;

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;

    typedef enum logic {
        LB_IDLE = 1'b0,
        LB_WAIT = 1'b1
    } linebuf_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Power-of-two circular byte FIFO with occupancy count; head is read combinationally.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // pointers are exactly AW bits wide, so increment wraps modulo DEPTH
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_rx_linebuf.sv
// Drains uart_sat RX bytes into a FIFO, counts buffered lines, streams bytes out.
// Optional echo slot enabled by defining UART_LINEBUF_ECHO_EN.
module uart_rx_linebuf
    import uart_pkg::*;
#(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  TERM  = CHAR_LF,
    localparam int         CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          clr_rdy,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [CW-1:0] level,
    output logic [CW-1:0] line_cnt,
    output logic          line_avail,
    output logic          overflow,
`ifdef UART_LINEBUF_ECHO_EN
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
`endif
    input  logic          ovf_clr
);

    linebuf_state_e state_q, state_d;
    logic           clr_rdy_q, clr_rdy_d;
    logic [CW-1:0]  line_cnt_q, line_cnt_d;
    logic           overflow_q, overflow_d;
    logic           can_cap, capture, push, pop, full, empty;

`ifdef UART_LINEBUF_ECHO_EN
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    // a slot being emptied this edge may be refilled on the same edge
    assign can_cap  = !tx_valid_q || tx_ready;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
`else
    assign can_cap = 1'b1;
`endif

    uart_byte_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (rx_data),
        .pop   (pop),
        .rdata (m_data),
        .count (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= LB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LB_IDLE: if (rx_rdy && can_cap) state_d = LB_WAIT;
            LB_WAIT: if (!rx_rdy)           state_d = LB_IDLE;
            default:                        state_d = LB_IDLE;
        endcase
    end

    always_comb begin
        capture   = (state_q == LB_IDLE) && rx_rdy && can_cap;
        clr_rdy_d = capture;
    end

    assign m_valid    = !empty;
    assign m_last     = !empty && (m_data == TERM);
    assign clr_rdy    = clr_rdy_q;
    assign line_cnt   = line_cnt_q;
    assign line_avail = (line_cnt_q != '0);
    assign overflow   = overflow_q;

    always_comb begin
        // fullness is judged before any same-cycle pop
        push       = capture && !full;
        pop        = m_valid && m_ready;
        line_cnt_d = line_cnt_q;
        case ({push && (rx_data == TERM), pop && m_last})
            2'b10:   line_cnt_d = line_cnt_q + 1'b1;
            2'b01:   line_cnt_d = line_cnt_q - 1'b1;
            default: line_cnt_d = line_cnt_q;
        endcase
        overflow_d = overflow_q;
        if (capture && full) overflow_d = 1'b1;
        else if (ovf_clr)    overflow_d = 1'b0;
`ifdef UART_LINEBUF_ECHO_EN
        tx_data_d  = capture ? rx_data : tx_data_q;
        tx_valid_d = capture ? 1'b1 : (tx_valid_q && !tx_ready);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_rdy_q  <= 1'b0;
            line_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            clr_rdy_q  <= clr_rdy_d;
            line_cnt_q <= line_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_LINEBUF_ECHO_EN
    always_ff @(posedge clk) begin
        if (rst) tx_valid_q <= 1'b0;
        else     tx_valid_q <= tx_valid_d;
    end

    always_ff @(posedge clk) begin
        tx_data_q <= tx_data_d;
    end
`endif

endmodule

// File: tb/tb_uart_rx_linebuf.sv
// Scoreboard bench for uart_rx_linebuf: stimulus queues expected bytes, a monitor checks pops.
module tb_uart_rx_linebuf;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          clr_rdy;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] level;
    logic [CW-1:0] line_cnt;
    logic          line_avail;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    uart_rx_linebuf #(.DEPTH(DEPTH), .TERM(8'h0A)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rdy    (clr_rdy),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .level      (level),
        .line_cnt   (line_cnt),
        .line_avail (line_avail),
        .overflow   (overflow),
`ifdef UART_LINEBUF_ECHO_EN
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
`endif
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int clr_cnt = 0;
    logic [8:0] exp_q [$];   // {last, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) if (clr_rdy === 1'b1) clr_cnt++;

    // pop happens on the coming edge whenever valid && ready is seen here
    always @(negedge clk) begin
        if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", {23'd0, m_last, m_data}, 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("pop_data", {24'd0, m_data}, {24'd0, e[7:0]});
                check("pop_last", {31'd0, m_last}, {31'd0, e[8]});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer one byte like uart_sat: hold rx_rdy until clr_rdy is seen, then drop it.
    task automatic send(input logic [7:0] b, input bit exp_push, input bit pop_same, input bit clr_same);
        int c0;
        int n;
        c0 = clr_cnt;
        if (exp_push) exp_q.push_back({b == 8'h0A, b});
        rx_data = b;
        rx_rdy  = 1'b1;
        if (pop_same) m_ready = 1'b1;
        if (clr_same) ovf_clr = 1'b1;
        tick();
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        n = 0;
        @(negedge clk);
        while (clr_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("clr_timeout", 32'd0, 32'd1);
        else if (exp_push) check("m_valid_after_push", {31'd0, m_valid}, 32'd1);
        tick();
        rx_rdy = 1'b0;
        tick();
        check("clr_pulses", clr_cnt - c0, 32'd1);
    endtask

    task automatic pop_n(input int n);
        m_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 m_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'h99;
        m_ready = 1'b0; ovf_clr = 1'b0; tx_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_clr_rdy",   {31'd0, clr_rdy},    32'd0);
        check("rst_m_valid",   {31'd0, m_valid},    32'd0);
        check("rst_m_last",    {31'd0, m_last},     32'd0);
        check("rst_level",     32'(level),          32'd0);
        check("rst_line_cnt",  32'(line_cnt),       32'd0);
        check("rst_line_avail",{31'd0, line_avail}, 32'd0);
        check("rst_overflow",  {31'd0, overflow},   32'd0);
`ifdef UART_LINEBUF_ECHO_EN
        check("rst_tx_valid",  {31'd0, tx_valid},   32'd0);
`endif
        check("rst_no_clr",    clr_cnt,             32'd0);
        tick();
        rst = 1'b0; rx_rdy = 1'b0;
        tick();

        // single byte
        send(8'h41, 1, 0, 0);
        @(negedge clk);
        check("b41_data",     {24'd0, m_data},    32'h41);
        check("b41_last",     {31'd0, m_last},    32'd0);
        check("b41_level",    32'(level),         32'd1);
        check("b41_line_cnt", 32'(line_cnt),      32'd0);
        tick();
        pop_n(1);
        @(negedge clk);
        check("b41_empty",    {31'd0, m_valid},   32'd0);

        // "HI\n"
        tick();
        send(8'h48, 1, 0, 0);
        send(8'h49, 1, 0, 0);
        send(8'h0A, 1, 0, 0);
        @(negedge clk);
        check("hi_line_cnt",  32'(line_cnt),      32'd1);
        check("hi_line_avail",{31'd0, line_avail},32'd1);
        check("hi_level",     32'(level),         32'd3);
        tick();
        pop_n(3);
        @(negedge clk);
        check("hi_line_cnt0", 32'(line_cnt),      32'd0);
        check("hi_valid0",    {31'd0, m_valid},   32'd0);
        check("hi_level0",    32'(level),         32'd0);

        // fill to full, then drop 0x55
        tick();
        for (int i = 0; i < DEPTH; i++) send((i == 5) ? 8'h0A : 8'(8'h60 + i), 1, 0, 0);
        @(negedge clk);
        check("fill_level",   32'(level),         32'd16);
        check("fill_ovf0",    {31'd0, overflow},  32'd0);
        tick();
        send(8'h55, 0, 0, 0);
        @(negedge clk);
        check("drop_level",   32'(level),         32'd16);
        check("drop_ovf",     {31'd0, overflow},  32'd1);
        check("drop_line_cnt",32'(line_cnt),      32'd1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared",  {31'd0, overflow},  32'd0);

        // full + simultaneous pop and LF push; ovf_clr on the same edge loses
        tick();
        send(8'h0A, 0, 1, 1);
        @(negedge clk);
        check("pp_level",     32'(level),         32'd15);
        check("pp_ovf",       {31'd0, overflow},  32'd1);
        check("pp_line_cnt",  32'(line_cnt),      32'd1);
        tick();
        pop_n(15);
        @(negedge clk);
        check("drain_level",  32'(level),         32'd0);
        check("drain_lines",  32'(line_cnt),      32'd0);

`ifdef UART_LINEBUF_ECHO_EN
        begin
            int c0;
            int n;
            tick();
            tx_ready = 1'b0;
            send(8'h31, 1, 0, 0);
            @(negedge clk);
            check("echo1_valid", {31'd0, tx_valid}, 32'd1);
            check("echo1_data",  {24'd0, tx_data},  32'h31);
            tick();
            c0 = clr_cnt;
            exp_q.push_back({1'b0, 8'h32});
            rx_data = 8'h32; rx_rdy = 1'b1;
            repeat (3) tick();
            @(negedge clk);
            check("echo_blocked_clr", clr_cnt - c0, 32'd0);
            check("echo_hold_data",   {24'd0, tx_data}, 32'h31);
            check("echo_hold_level",  32'(level),       32'd1);
            tick();
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            n = 0;
            @(negedge clk);
            while (clr_rdy !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("echo2_clr_seen", {31'd0, clr_rdy}, 32'd1);
            tick();
            rx_rdy = 1'b0;
            tick();
            @(negedge clk);
            check("echo2_valid", {31'd0, tx_valid}, 32'd1);
            check("echo2_data",  {24'd0, tx_data},  32'h32);
            check("echo2_level", 32'(level),        32'd2);
            tick();
            tx_ready = 1'b1;
            pop_n(2);
        end
`endif

        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
